// File: rtl/framebuffer_reader.sv
// framebuffer_reader: Avalon-MM read master streaming one frame of pixels into the pixel FIFO
module framebuffer_reader #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        fifo_almost_full,
  output logic [31:0] fifo_wdata,
  output logic        fifo_winc,
  output logic        busy,
  output logic        frame_done
);
  localparam int N  = HDISP * VDISP;
  localparam int IW = $clog2(N);
  typedef enum logic [2:0] {IDLE, HOLD, REQ, WAIT, WR} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          last;
  assign last = idx_q == IW'(N - 1);
  // WR is the FIFO write cycle; it also gives the 3-cycle minimum word spacing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        idx_d   = '0;
        state_d = fifo_almost_full ? HOLD : REQ;
      end
      HOLD: state_d = fifo_almost_full ? HOLD : REQ;
      REQ:  state_d = avm_waitrequest ? REQ : WAIT;
      WAIT: if (avm_readdatavalid) begin
        wdata_d = avm_readdata;
        state_d = WR;
      end
      WR: begin
        done_d  = last;
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? IDLE : (fifo_almost_full ? HOLD : REQ);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end
  assign avm_read    = state_q == REQ;
  assign avm_address = BASE_ADDR + (32'(idx_q) << 2);
  assign fifo_winc   = state_q == WR;
  assign fifo_wdata  = wdata_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = done_q;
endmodule
